mem_arbiter: RTL and testbench

//  Shares one single-port synchronous RAM between the instruction-fetch port (f_*) and the

---
 rtl/mem_arbiter.sv | 113 +++++++++++
 tb/tb_mem_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port RAM between the fetch and data ports, with a starvation bound on fetch.
// Define MEM_ARB_SNOOP_EN to enable the fetch/data-write snoop that drives f_inval_o.
module mem_arbiter #(
  parameter int MEM_AW   = 10,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req_i,
  input  logic [31:0]       f_addr_i,
  output logic              f_gnt_o,
  output logic              f_rvalid_o,
  output logic [31:0]       f_rdata_o,
  output logic              f_inval_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [31:0]       d_addr_i,
  input  logic [31:0]       d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [31:0]       d_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);

  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {OWN_NONE, OWN_F, OWN_D} owner_e;

  owner_e          owner_q, owner_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic            wait_full;
  logic [MEM_AW-1:0] f_waddr, d_waddr;

  assign f_waddr   = f_addr_i[MEM_AW+1:2];
  assign d_waddr   = d_addr_i[MEM_AW+1:2];
  assign wait_full = (wait_q == WW'(MAX_WAIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q <= OWN_NONE;
      wait_q  <= '0;
    end else begin
      owner_q <= owner_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    f_gnt_o = 1'b0;
    d_gnt_o = 1'b0;
    owner_d = OWN_NONE;
    wait_d  = '0;
    if (!rst) begin
      // Data wins ties unless fetch has already been denied MAX_WAIT cycles in a row.
      f_gnt_o = f_req_i && (!d_req_i || wait_full);
      d_gnt_o = d_req_i && !f_gnt_o;
    end
    if (f_gnt_o)
      owner_d = OWN_F;
    else if (d_gnt_o && !d_we_i)
      owner_d = OWN_D;
    if (f_req_i && !f_gnt_o)
      wait_d = wait_full ? wait_q : wait_q + WW'(1);
  end

  assign mem_en_o    = f_gnt_o | d_gnt_o;
  assign mem_we_o    = d_gnt_o & d_we_i;
  assign mem_addr_o  = f_gnt_o ? f_waddr : d_waddr;
  assign mem_wdata_o = d_wdata_i;

  assign f_rvalid_o = (owner_q == OWN_F);
  assign d_rvalid_o = (owner_q == OWN_D);
  assign f_rdata_o  = mem_rdata_i;
  assign d_rdata_o  = mem_rdata_i;

`ifdef MEM_ARB_SNOOP_EN
  logic [MEM_AW-1:0] last_f_waddr_q;
  logic              last_f_valid_q;
  logic              f_inval_q;
  logic              snoop_hit;

  assign snoop_hit = mem_we_o && last_f_valid_q && (d_waddr == last_f_waddr_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_f_waddr_q <= '0;
      last_f_valid_q <= 1'b0;
      f_inval_q      <= 1'b0;
    end else begin
      f_inval_q <= snoop_hit;
      if (f_gnt_o) begin
        last_f_waddr_q <= f_waddr;
        last_f_valid_q <= 1'b1;
      end else if (snoop_hit) begin
        last_f_valid_q <= 1'b0;
      end
    end
  end

  assign f_inval_o = f_inval_q;
`else
  assign f_inval_o = 1'b0;
`endif

  logic unused_addr_bits;
  assign unused_addr_bits = ^{f_addr_i[31:MEM_AW+2], f_addr_i[1:0],
                              d_addr_i[31:MEM_AW+2], d_addr_i[1:0]};

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter; a RAM model and a spec-level reference model
// predict grants, read data and snoop invalidations each cycle.
module tb_mem_arbiter;
  localparam int AW = 10;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          f_req_i = 1'b0, d_req_i = 1'b0, d_we_i = 1'b0;
  logic [31:0]   f_addr_i = '0, d_addr_i = '0, d_wdata_i = '0;
  logic          f_gnt_o, f_rvalid_o, f_inval_o, d_gnt_o, d_rvalid_o;
  logic [31:0]   f_rdata_o, d_rdata_o, mem_wdata_o;
  logic          mem_en_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_rdata_i = '0;

  mem_arbiter #(.MEM_AW(AW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .f_req_i(f_req_i), .f_addr_i(f_addr_i), .f_gnt_o(f_gnt_o), .f_rvalid_o(f_rvalid_o),
    .f_rdata_o(f_rdata_o), .f_inval_o(f_inval_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int i);
    return 32'(i) * 32'h9E37_79B9 + 32'h1234_5678;
  endfunction

  // Environment RAM
  logic [31:0] ram [0:(1<<AW)-1];
  initial for (int i = 0; i < (1<<AW); i++) ram[i] = init_word(i);
  always @(posedge clk) begin
    if (mem_en_o && mem_we_o) ram[mem_addr_o] <= mem_wdata_o;
    if (mem_en_o && !mem_we_o) mem_rdata_i <= ram[mem_addr_o];
  end

  // Reference model state
  logic [31:0]   shadow [0:(1<<AW)-1];
  int            m_wait = 0;
  int            m_own  = 0;   // 0 none, 1 fetch, 2 data
  logic [31:0]   m_exp  = '0;
  logic [AW-1:0] m_lf   = '0;
  bit            m_lfv  = 0;
  bit            m_inval = 0;
  initial for (int i = 0; i < (1<<AW); i++) shadow[i] = init_word(i);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_wait = 0; m_own = 0; m_lfv = 0; m_inval = 0;
  endtask

  // One clock cycle: drive after negedge, check combinational and registered outputs, advance model.
  task automatic step(input bit fr, input logic [31:0] fa, input bit dr, input bit dwe,
                      input logic [31:0] da, input logic [31:0] dwd, output bit gf, output bit gd);
    logic [AW-1:0] fw, dw, aw;
    f_req_i = fr; f_addr_i = fa; d_req_i = dr; d_we_i = dwe; d_addr_i = da; d_wdata_i = dwd;
    #1;
    fw = fa[AW+1:2];
    dw = da[AW+1:2];
    gf = fr && (!dr || m_wait == MW);
    gd = dr && !gf;
    aw = gf ? fw : dw;
    chk("f_gnt", f_gnt_o, gf);
    chk("d_gnt", d_gnt_o, gd);
    chk("mem_en", mem_en_o, gf | gd);
    chk("mem_we", mem_we_o, gd & dwe);
    if (gf | gd) chk("mem_addr", mem_addr_o, aw);
    if (gd && dwe) chk("mem_wdata", mem_wdata_o, dwd);
    chk("f_rvalid", f_rvalid_o, m_own == 1);
    chk("d_rvalid", d_rvalid_o, m_own == 2);
    if (m_own == 1) chk("f_rdata", f_rdata_o, m_exp);
    if (m_own == 2) chk("d_rdata", d_rdata_o, m_exp);
    chk("f_inval", f_inval_o, m_inval);
    m_own = gf ? 1 : (gd && !dwe) ? 2 : 0;
    if (m_own != 0) m_exp = shadow[aw];
    if (gd && dwe) shadow[dw] = dwd;
    m_inval = 0;
`ifdef MEM_ARB_SNOOP_EN
    if (gf) begin m_lf = fw; m_lfv = 1; end
    if (gd && dwe && m_lfv && dw == m_lf) begin m_inval = 1; m_lfv = 0; end
`endif
    m_wait = (fr && !gf) ? ((m_wait < MW) ? m_wait + 1 : MW) : 0;
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] r;
    r = $urandom;
    r[AW+1:2] = AW'($urandom_range(0, 15));
    return r;
  endfunction

  initial begin
    bit gf, gd, fp, dp, dwe;
    logic [31:0] fa, da, dwd;

    repeat (2) @(negedge clk);
    chk("rst_f_rvalid", f_rvalid_o, 1'b0);
    chk("rst_d_rvalid", d_rvalid_o, 1'b0);
    chk("rst_mem_en", mem_en_o, 1'b0);
    rst = 1'b0;

    // 1: lone fetch
    step(1, 32'h100, 0, 0, 0, 0, gf, gd);
    step(0, 0, 0, 0, 0, 0, gf, gd);
    chk("t1_data", f_rdata_o, init_word(32'h40));

    // 2: both held -> D,D,D,D,F repeating
    for (int i = 0; i < 10; i++) begin
      step(1, 32'h8, 1, 0, 32'hC, 0, gf, gd);
      chk("t2_seq_f", gf, (i % 5) == 4);
      chk("t2_any", gf | gd, 1'b1);
    end
    step(0, 0, 0, 0, 0, 0, gf, gd);

    // 3: write then read-after-write
    step(0, 0, 1, 1, 32'h200, 32'hDEADBEEF, gf, gd);
    chk("t3_no_rvalid_wr", d_rvalid_o, 1'b0);
    step(0, 0, 1, 0, 32'h200, 0, gf, gd);
    chk("t3_rvalid", d_rvalid_o, 1'b1);
    chk("t3_raw", d_rdata_o, 32'hDEADBEEF);
    step(0, 0, 0, 0, 0, 0, gf, gd);

    // 4: alternating fetch / data reads
    for (int i = 0; i < 8; i++) begin
      step(i % 2 == 0, 32'h0, i % 2 == 1, 0, 32'h4, 0, gf, gd);
      chk("t4_both", f_rvalid_o & d_rvalid_o, 1'b0);
    end
    step(0, 0, 0, 0, 0, 0, gf, gd);

    // 5: snoop
    step(1, 32'h300, 0, 0, 0, 0, gf, gd);
    step(0, 0, 1, 1, 32'h300, 32'h1111_2222, gf, gd);
`ifdef MEM_ARB_SNOOP_EN
    chk("t5_inval_hit", f_inval_o, 1'b1);
`else
    chk("t5_inval_off", f_inval_o, 1'b0);
`endif
    step(1, 32'h300, 0, 0, 0, 0, gf, gd);
    step(0, 0, 1, 1, 32'h304, 32'h3333_4444, gf, gd);
    chk("t5_inval_miss", f_inval_o, 1'b0);
    step(0, 0, 0, 0, 0, 0, gf, gd);

    // 6: reset right after a read grant, with fetch partly starved
    step(1, 32'h100, 1, 0, 32'h20, 0, gf, gd);
    step(1, 32'h100, 1, 0, 32'h20, 0, gf, gd);
    rst = 1'b1;
    #1;
    chk("t6_d_rvalid", d_rvalid_o, 1'b0);
    chk("t6_f_rvalid", f_rvalid_o, 1'b0);
    chk("t6_f_gnt", f_gnt_o, 1'b0);
    chk("t6_d_gnt", d_gnt_o, 1'b0);
    chk("t6_mem_en", mem_en_o, 1'b0);
    chk("t6_mem_we", mem_we_o, 1'b0);
    chk("t6_inval", f_inval_o, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      step(1, 32'h8, 1, 0, 32'hC, 0, gf, gd);
      chk("t6_wait_cleared", gf, i == 4);
    end
    step(1, 32'h100, 0, 0, 0, 0, gf, gd);
    step(0, 0, 0, 0, 0, 0, gf, gd);
    chk("t6_case1", f_rdata_o, init_word(32'h40));

    // Randomized traffic with requests held until granted
    fp = 0; dp = 0; dwe = 0; fa = '0; da = '0; dwd = '0;
    for (int i = 0; i < 400; i++) begin
      if (!fp && $urandom_range(0, 2) != 0) begin fp = 1; fa = rand_addr(); end
      if (!dp && $urandom_range(0, 1) != 0) begin
        dp = 1; dwe = $urandom_range(0, 1) != 0; da = rand_addr(); dwd = $urandom;
      end
      step(fp, fa, dp, dwe, da, dwd, gf, gd);
      if (gf) fp = 0;
      if (gd) dp = 0;
    end
    step(0, 0, 0, 0, 0, 0, gf, gd);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
